// File: rtl/fault_xor_tree.sv
// fault_xor_tree
//   Pipelined XOR reduction (parity) of WIDTH inputs with per-site fault
//   injection. Sites 0..WIDTH-1 are the din bits (faulted at capture), site
//   WIDTH is the output (faulted at the input of the final register).
//   Each site can be none / stuck-0 / stuck-1 / invert. One transient fault
//   may be counting down at a time; when it expires its site returns to none.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   in_valid, din    sample to reduce (no backpressure)
//   out_valid, dout  result STAGES cycles after capture; dout holds on bubbles
//   fault_wr         write a fault record (fault_sel, fault_mode, fault_dur)
//   fault_clr        clear all sites and cancel any transient; beats fault_wr
//   fault_busy       a transient fault is counting down
//   fault_err        one-cycle pulse after a rejected write
//
// Build option
//   FAULT_REGISTER_EN  simulation-only reporting of fault sites and fault
//                      events; the logic is identical either way.

module fault_xor_tree #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNTW   = 8,
  localparam int SELW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  output logic             dout,
  input  logic             fault_wr,
  input  logic [SELW-1:0]  fault_sel,
  input  logic [1:0]       fault_mode,
  input  logic [CNTW-1:0]  fault_dur,
  input  logic             fault_clr,
  output logic             fault_busy,
  output logic             fault_err
);

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_S0   = 2'b01;
  localparam logic [1:0] MODE_S1   = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

  function automatic logic apply_fault(logic b, logic [1:0] m);
    case (m)
      MODE_S0:  return 1'b0;
      MODE_S1:  return 1'b1;
      MODE_INV: return ~b;
      default:  return b;
    endcase
  endfunction

  // ---------------- fault state ----------------
  logic [1:0]      mode_q [WIDTH+1];
  logic [1:0]      mode_d [WIDTH+1];
  logic [CNTW-1:0] timer_q, timer_d;
  logic [SELW-1:0] tsite_q, tsite_d;
  logic            err_q, err_d;
  logic            sel_ok, accept, reject;

  assign fault_busy = (timer_q != '0);
  assign fault_err  = err_q;

  assign sel_ok = (fault_sel <= SELW'(WIDTH));
  assign accept = fault_wr & ~fault_clr & sel_ok & ~((fault_dur != '0) & fault_busy);
  assign reject = fault_wr & ~fault_clr & ~accept;

  always_comb begin
    mode_d  = mode_q;
    timer_d = timer_q;
    tsite_d = tsite_q;
    err_d   = reject;
    if (fault_clr) begin
      for (int i = 0; i <= WIDTH; i++) mode_d[i] = MODE_NONE;
      timer_d = '0;
    end else if (accept) begin
      // A permanent write (dur 0) zeroes the timer, cancelling any transient;
      // the previously transient site then keeps its mode.
      mode_d[fault_sel] = fault_mode;
      timer_d           = fault_dur;
      tsite_d           = fault_sel;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
      if (timer_q == CNTW'(1)) mode_d[tsite_q] = MODE_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= WIDTH; i++) mode_q[i] <= MODE_NONE;
      timer_q <= '0;
      tsite_q <= '0;
      err_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      timer_q <= timer_d;
      tsite_q <= tsite_d;
      err_q   <= err_d;
    end
  end

  // ---------------- datapath ----------------
  logic [WIDTH-1:0]  din_f;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] par_q, par_d;
  logic [STAGES-1:0] stg_in;

  always_comb begin
    din_f = din;
    for (int i = 0; i < WIDTH; i++) din_f[i] = apply_fault(din[i], mode_q[i]);
  end

  always_comb begin
    vld_d     = '0;
    stg_in    = '0;
    vld_d[0]  = in_valid;
    stg_in[0] = ^din_f;
    for (int s = 1; s < STAGES; s++) begin
      vld_d[s]  = vld_q[s-1];
      stg_in[s] = par_q[s-1];
    end
    par_d = stg_in;
    // Final stage only loads on a valid sample so dout holds across bubbles;
    // the output-site fault is taken from the state current at this stage.
    par_d[STAGES-1] = vld_d[STAGES-1] ? apply_fault(stg_in[STAGES-1], mode_q[WIDTH])
                                      : par_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      par_q <= '0;
    end else begin
      vld_q <= vld_d;
      par_q <= par_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign dout      = par_q[STAGES-1];

`ifdef FAULT_REGISTER_EN
  initial begin
    for (int i = 0; i < WIDTH; i++) $display("register  %m.site_%0d input", i);
    $display("register  %m.site_%0d output", WIDTH);
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (accept)
        $display("%m: fault write site=%0d mode=%0d dur=%0d t=%0t",
                 fault_sel, fault_mode, fault_dur, $time);
      if (reject)
        $display("%m: fault write rejected site=%0d mode=%0d t=%0t",
                 fault_sel, fault_mode, $time);
      if (!fault_clr && !accept && timer_q == CNTW'(1))
        $display("%m: transient expired site=%0d mode=%0d t=%0t",
                 tsite_q, MODE_NONE, $time);
    end
  end
`endif

endmodule

// File: tb/tb_fault_xor_tree.sv
module tb_fault_xor_tree;
  localparam int W  = 8;
  localparam int CW = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0]  din = '0;
  logic fault_wr = 1'b0;
  logic fault_clr = 1'b0;
  logic [SW-1:0] fault_sel = '0;
  logic [1:0]    fault_mode = '0;
  logic [CW-1:0] fault_dur = '0;
  logic [2:0] ov, dv, busy, ferr;

  always #5 clk = ~clk;

  fault_xor_tree #(.WIDTH(W), .STAGES(1), .CNTW(CW)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .out_valid(ov[0]), .dout(dv[0]), .fault_wr(fault_wr), .fault_sel(fault_sel),
    .fault_mode(fault_mode), .fault_dur(fault_dur), .fault_clr(fault_clr),
    .fault_busy(busy[0]), .fault_err(ferr[0]));
  fault_xor_tree #(.WIDTH(W), .STAGES(2), .CNTW(CW)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .out_valid(ov[1]), .dout(dv[1]), .fault_wr(fault_wr), .fault_sel(fault_sel),
    .fault_mode(fault_mode), .fault_dur(fault_dur), .fault_clr(fault_clr),
    .fault_busy(busy[1]), .fault_err(ferr[1]));
  fault_xor_tree #(.WIDTH(W), .STAGES(4), .CNTW(CW)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
    .out_valid(ov[2]), .dout(dv[2]), .fault_wr(fault_wr), .fault_sel(fault_sel),
    .fault_mode(fault_mode), .fault_dur(fault_dur), .fault_clr(fault_clr),
    .fault_busy(busy[2]), .fault_err(ferr[2]));

  int stg [3] = '{1, 2, 4};

  // ---------------- reference model ----------------
  // Fault state per site; a transient is tracked by the absolute cycle of its
  // last active cycle (t_end), -1 when none is running.
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic [1:0] m_mode [W+1];
  int         t_end = -1;
  int         t_site = 0;
  bit         m_err = 1'b0;
  logic [1:0] ohist [4096];
  bit         chk_en = 1'b0;

  typedef struct {
    int cap;
    bit par;
  } sb_t;
  sb_t q [3][$];
  bit  exp_d [3];

  function automatic bit fapply(bit b, logic [1:0] m);
    case (m)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return !b;
      default: return b;
    endcase
  endfunction

  task automatic check(string nm, int s, logic got, logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s S=%0d cyc=%0d got=%0b expected=%0b", nm, s, cyc, got, exp);
    end
  endtask

  // One clock: score the sample presented this cycle, then advance the model
  // across the edge using the inputs that edge samples.
  task automatic step();
    bit par;
    bit accept;
    ohist[cyc % 4096] = m_mode[W];
    if (in_valid && !rst) begin
      par = 1'b0;
      for (int i = 0; i < W; i++) par ^= fapply(din[i], m_mode[i]);
      for (int j = 0; j < 3; j++) q[j].push_back('{cyc, par});
    end
    @(posedge clk);
    m_err = 1'b0;
    if (rst) begin
      for (int i = 0; i <= W; i++) m_mode[i] = 2'b00;
      t_end = -1;
      for (int j = 0; j < 3; j++) begin
        q[j].delete();
        exp_d[j] = 1'b0;
      end
    end else if (fault_clr) begin
      for (int i = 0; i <= W; i++) m_mode[i] = 2'b00;
      t_end = -1;
    end else begin
      accept = fault_wr && (int'(fault_sel) <= W) && !(fault_dur != 0 && t_end >= cyc);
      if (fault_wr && !accept) m_err = 1'b1;
      if (accept) begin
        m_mode[fault_sel] = fault_mode;
        if (fault_dur != 0) begin
          t_end  = cyc + int'(fault_dur);
          t_site = int'(fault_sel);
        end else begin
          t_end = -1;
        end
      end else if (t_end == cyc) begin
        m_mode[t_site] = 2'b00;
        t_end = -1;
      end
    end
    cyc++;
    #1;
  endtask

  // ---------------- monitor ----------------
  sb_t mon_e;
  bit  mon_v;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int j = 0; j < 3; j++) begin
        mon_v = (q[j].size() > 0) && (q[j][0].cap + stg[j] == cyc);
        check("out_valid", stg[j], ov[j], mon_v);
        if (mon_v) begin
          mon_e = q[j].pop_front();
          exp_d[j] = fapply(mon_e.par, ohist[(mon_e.cap + stg[j] - 1) % 4096]);
        end
        check("dout", stg[j], dv[j], exp_d[j]);
        check("fault_busy", stg[j], busy[j], t_end >= cyc);
        check("fault_err", stg[j], ferr[j], m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic quiet();
    in_valid = 1'b0; fault_wr = 1'b0; fault_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(int n);
    quiet();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send(logic [W-1:0] d);
    quiet();
    in_valid = 1'b1; din = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wr(int sel, int mode, int dur);
    quiet();
    fault_wr = 1'b1; fault_sel = SW'(sel); fault_mode = 2'(mode); fault_dur = CW'(dur);
    step();
    fault_wr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i <= W; i++) m_mode[i] = 2'b00;
    for (int j = 0; j < 3; j++) exp_d[j] = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // fault-free parity, back-to-back with a bubble
    send(8'hA5); send(8'h01); idle(1); send(8'h80); send(8'hFF); idle(5);

    // permanent input and output faults
    wr(3, 2, 0); send(8'h00); send(8'h08); idle(4);
    wr(8, 1, 0); send(8'h01); send(8'h00); send(8'h7F); idle(5);
    quiet(); fault_clr = 1'b1; step(); idle(2);

    // transient invert on site 0 for 3 cycles, zeros every cycle
    quiet();
    fault_wr = 1'b1; fault_sel = 0; fault_mode = 2'b11; fault_dur = 3;
    in_valid = 1'b1; din = 8'h00;
    step();
    fault_wr = 1'b0;
    for (int k = 0; k < 6; k++) step();
    idle(5);

    // second transient while busy, then out-of-range site
    wr(0, 3, 5); wr(1, 2, 2); wr(9, 1, 0); send(8'h00); idle(6);
    // permanent write to the busy site cancels the countdown
    wr(2, 2, 6); idle(1); wr(2, 1, 0); send(8'h04); idle(8);
    quiet(); fault_clr = 1'b1; step();

    // write and clear together: clear wins, no error
    quiet(); fault_wr = 1'b1; fault_clr = 1'b1; fault_sel = 5; fault_mode = 2'b10; fault_dur = 0;
    step(); send(8'h00); idle(5);

    // reset mid-transient
    wr(2, 3, 10); idle(5);
    quiet(); rst = 1'b1; step(); rst = 1'b0;
    send(8'h00); send(8'h04); idle(5);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      in_valid   = ($urandom_range(0, 9) < 8);
      din        = W'($urandom);
      fault_wr   = ($urandom_range(0, 7) == 0);
      fault_sel  = SW'($urandom_range(0, 10));
      fault_mode = 2'($urandom_range(0, 3));
      fault_dur  = ($urandom_range(0, 1) == 0) ? CW'(0) : CW'($urandom_range(1, 6));
      fault_clr  = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    idle(6);
    for (int j = 0; j < 3; j++) check("drain", stg[j], q[j].size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
